// File: rtl/maxterm_extractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maxterm_extractor_pkg
//  Purpose  : Shared state encoding and sizing constants for the maxterm
//             extractor and its row sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package maxterm_extractor_pkg;

    localparam int NUM_VARS = 4;
    localparam int NUM_ROWS = 16;
    localparam int SETTLE_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/maxterm_extractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : maxterm_extractor_if
//  Purpose  : Control, truth-table probe and result bundle of the maxterm
//             extractor. The slave side is the extractor itself.
//  Revision : 1.0  initial release
// ============================================================================
interface maxterm_extractor_if;
    import maxterm_extractor_pkg::*;

    logic                start;
    logic [SETTLE_W-1:0] settle;
    logic                X;
    logic                Y;
    logic                W;
    logic                Z;
    logic                s_a;
    logic                s_b;
    logic                busy;
    logic                done;
    logic [NUM_ROWS-1:0] maxterms;
    logic [NUM_ROWS-1:0] mismatch;
    logic [4:0]          zero_count;
    logic                equal;

    modport master (
        output start, settle, s_a, s_b,
        input  X, Y, W, Z, busy, done, maxterms, mismatch, zero_count, equal
    );

    modport slave (
        input  start, settle, s_a, s_b,
        output X, Y, W, Z, busy, done, maxterms, mismatch, zero_count, equal
    );
endinterface
`default_nettype wire

// File: rtl/maxterm_extractor_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : row_sequencer
//  Purpose  : Owns the row index and the per-row settle countdown. Raises
//             sample_en on the last cycle of each row; holds at row 15 after
//             the final sample so the index never wraps.
//  Revision : 1.0  initial release
// ============================================================================
module row_sequencer
    import maxterm_extractor_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                load,
    input  wire logic                enable,
    input  wire logic [SETTLE_W-1:0] settle,
    output logic [NUM_VARS-1:0]      row,
    output logic                     sample_en,
    output logic                     last_row
);

    logic [NUM_VARS-1:0] r_row;
    logic [SETTLE_W-1:0] r_wait;
    logic [SETTLE_W-1:0] r_settle;

    assign row       = r_row;
    assign sample_en = enable && (r_wait == '0);
    assign last_row  = (r_row == NUM_VARS'(NUM_ROWS - 1));

    // Row/wait advance: load restarts at row 0, each row lasts settle+1 cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row    <= '0;
            r_wait   <= '0;
            r_settle <= '0;
        end else if (load) begin
            r_row    <= '0;
            r_wait   <= settle;
            r_settle <= settle;
        end else if (enable) begin
            if (r_wait != '0) begin
                r_wait <= r_wait - SETTLE_W'(1);
            end else if (!last_row) begin
                r_row  <= r_row + NUM_VARS'(1);
                r_wait <= r_settle;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/maxterm_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : maxterm_extractor
//  Purpose  : Walks all 16 rows of a 4-input function, records the rows where
//             function A is 0 (maxterms) and where A differs from reference B.
//  Revision : 1.0  initial release
// ============================================================================
module maxterm_extractor
    import maxterm_extractor_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    maxterm_extractor_if.slave bus
);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic [NUM_ROWS-1:0] r_maxterms;
    logic [NUM_ROWS-1:0] r_mismatch;
    logic [4:0]          r_zero_count;

    logic                w_load;
    logic                w_enable;
    logic [NUM_VARS-1:0] w_row;
    logic                w_sample_en;
    logic                w_last_row;

    assign w_load   = (r_state == IDLE) && bus.start;
    assign w_enable = (r_state == DRIVE);

    row_sequencer u_row_sequencer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .enable    (w_enable),
        .settle    (bus.settle),
        .row       (w_row),
        .sample_en (w_sample_en),
        .last_row  (w_last_row)
    );

    // Scan control FSM plus result capture; results cleared on every accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_maxterms   <= '0;
            r_mismatch   <= '0;
            r_zero_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state      <= DRIVE;
                        r_busy       <= 1'b1;
                        r_valid      <= 1'b0;
                        r_maxterms   <= '0;
                        r_mismatch   <= '0;
                        r_zero_count <= '0;
                    end
                end
                DRIVE: begin
                    if (w_sample_en) begin
                        r_maxterms[w_row] <= ~bus.s_a;
                        r_mismatch[w_row] <= bus.s_a ^ bus.s_b;
                        if (!bus.s_a) begin
                            r_zero_count <= r_zero_count + 5'd1;
                        end
                        if (w_last_row) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Row lines are only driven while scanning; parked at 0 otherwise
    assign {bus.X, bus.Y, bus.W, bus.Z} = (r_state == DRIVE) ? w_row : '0;

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.maxterms   = r_maxterms;
    assign bus.mismatch   = r_mismatch;
    assign bus.zero_count = r_zero_count;
    assign bus.equal      = r_valid && (r_mismatch == '0);

endmodule
`default_nettype wire

// File: tb/tb_maxterm_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxterm_extractor
//  Purpose  : Self-checking bench: directed scenarios plus random truth tables
//             compared against a truth-table reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_maxterm_extractor;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [15:0] fa;
    logic [15:0] fb;

    maxterm_extractor_if bus ();

    maxterm_extractor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The functions under test: look up the row currently driven by the DUT
    always_comb begin
        bus.s_a = fa[{bus.X, bus.Y, bus.W, bus.Z}];
        bus.s_b = fb[{bus.X, bus.Y, bus.W, bus.Z}];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_xywz"},  32'({bus.X, bus.Y, bus.W, bus.Z}), 32'd0);
        check({tag, "_max"},   32'(bus.maxterms), 32'd0);
        check({tag, "_mis"},   32'(bus.mismatch), 32'd0);
        check({tag, "_zc"},    32'(bus.zero_count), 32'd0);
        check({tag, "_equal"}, 32'(bus.equal), 32'd0);
    endtask

    // Full scan with reference comparison; pulse_row >= 0 re-pulses start mid-scan
    task automatic run_scan(input string tag, input logic [15:0] a_tab, input logic [15:0] b_tab,
                            input logic [1:0] st, input int pulse_row);
        int          n;
        int          k;
        bit          got_done;
        logic [15:0] e_max;
        logic [15:0] e_mis;
        int          e_zc;

        e_max = '0;
        e_mis = '0;
        e_zc  = 0;
        for (int r = 0; r < 16; r++) begin
            if (a_tab[r] == 1'b0) begin
                e_max[r] = 1'b1;
                e_zc     = e_zc + 1;
            end
            if (a_tab[r] != b_tab[r]) e_mis[r] = 1'b1;
        end
        n = 16 * (int'(st) + 1);

        @(negedge clk);
        fa         = a_tab;
        fb         = b_tab;
        bus.settle = st;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);

        k        = 0;
        got_done = 1'b0;
        while (!got_done && k < 300) begin
            if (k < n) begin
                check({tag, "_row"}, 32'({bus.X, bus.Y, bus.W, bus.Z}), 32'(k / (int'(st) + 1)));
            end
            bus.start = (pulse_row >= 0 && k == pulse_row * (int'(st) + 1)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            k++;
            if (bus.done) got_done = 1'b1;
        end
        bus.start = 1'b0;

        check({tag, "_done_latency"}, 32'(k), 32'(n));
        check({tag, "_busy_done"},  32'(bus.busy), 32'd1);
        check({tag, "_xywz_done"},  32'({bus.X, bus.Y, bus.W, bus.Z}), 32'd0);
        check({tag, "_maxterms"},   32'(bus.maxterms), 32'(e_max));
        check({tag, "_mismatch"},   32'(bus.mismatch), 32'(e_mis));
        check({tag, "_zero_count"}, 32'(bus.zero_count), 32'(e_zc));
        check({tag, "_equal"},      32'(bus.equal), 32'(e_mis == 16'd0));

        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_max_hold"},   32'(bus.maxterms), 32'(e_max));
        check({tag, "_eq_hold"},    32'(bus.equal), 32'(e_mis == 16'd0));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        fa         = 16'hFFFF;
        fb         = 16'hFFFF;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.settle = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;

        // Scenario 6: reset wins over start on the same edge
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check_idle_zero("rst_start");
        @(posedge clk);
        #1;
        check("rst_start_busy2", 32'(bus.busy), 32'd0);

        // Scenario 1: product of maxterms M(1,2,5,13,14,15) -> table is ~0xE026
        run_scan("scn1", ~16'hE026, ~16'hE026, 2'd0, -1);
        check("scn1_literal_max", 32'(bus.maxterms), 32'h0000E026);
        check("scn1_literal_zc",  32'(bus.zero_count), 32'd6);

        // Scenario 2: reference differs at row 7 only
        run_scan("scn2", ~16'hE026, ~16'hE026 ^ 16'h0080, 2'd0, -1);
        check("scn2_literal_mis", 32'(bus.mismatch), 32'h00000080);

        // Scenario 3: constant-1 then constant-0 functions
        run_scan("scn3a", 16'hFFFF, 16'hFFFF, 2'd0, -1);
        run_scan("scn3b", 16'h0000, 16'h0000, 2'd0, -1);
        check("scn3b_literal_zc", 32'(bus.zero_count), 32'd16);

        // Scenario 4: settle=3 with a stray start pulse at row 5
        run_scan("scn4", ~16'hE026, ~16'hE026, 2'd3, 5);

        // Scenario 5: abort at row 9 with reset, then a clean rescan
        @(negedge clk);
        fa         = 16'h1234;
        fb         = 16'h1234;
        bus.settle = 2'd0;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("scn5_row9", 32'({bus.X, bus.Y, bus.W, bus.Z}), 32'd9);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero("scn5_abort");
        run_scan("scn5_rescan", ~16'hE026, ~16'hE026, 2'd0, -1);

        // Random truth tables and settle values
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra;
            logic [15:0] rmask;
            ra    = 16'($urandom);
            rmask = (i % 2 == 0) ? 16'd0 : 16'($urandom & $urandom);
            run_scan("rand", ra, ra ^ rmask, 2'($urandom_range(0, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
